// File: rtl/moc_ram.sv
// Byte-addressed data memory with a MAR/MDR request port and a one-cycle moc completion pulse.
// Latency, byte order and access size (byte/half/word with sign or zero extension) are configurable.
module moc_ram #(
  parameter int    ADDR_WIDTH = 9,
  parameter int    LATENCY    = 2,
  parameter bit    BIG_ENDIAN = 1'b1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mov,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc,
  output logic                  busy,
  output logic                  misaligned
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, nextState;
  logic [3:0]            cnt, cntNext;
  logic [7:0]            mem [DEPTH];

  logic                  rw_p1, sext_p1;
  logic [1:0]            size_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [31:0]           data_p1;

  logic                  inIdle, accept, alignErr;
  logic                  effRw, effSext;
  logic [1:0]            effSize;
  logic [ADDR_WIDTH-1:0] effAddr;
  logic [31:0]           effData;
  logic                  enterDone, commitWr, commitRd, mocNext, busyNext, misNext;
  logic [ADDR_WIDTH-1:0] laneAddr [4];
  logic [31:0]           rawRd;
  int                    nBytes;

  function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] lsb);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      2'b10:   return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic sx);
    case (sz)
      2'b00:   return {{24{sx & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{sx & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Position of the i-th addressed byte inside the right-justified value.
  function automatic int laneOf(input int i, input int n);
    return BIG_ENDIAN ? (n - 1 - i) : i;
  endfunction

  // Stage p1: request captured on the accept edge; inputs are free afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_p1   <= rw;
      sext_p1 <= sign_ext;
      size_p1 <= size;
      addr_p1 <= addr;
      data_p1 <= data_in;
    end
  end

  // With LATENCY=1 the accept edge is also the completion edge, so the live inputs are used in IDLE.
  assign inIdle   = (state == IDLE);
  assign accept   = inIdle & mov;
  assign effRw    = inIdle ? rw       : rw_p1;
  assign effSext  = inIdle ? sign_ext : sext_p1;
  assign effSize  = inIdle ? size     : size_p1;
  assign effAddr  = inIdle ? addr     : addr_p1;
  assign effData  = inIdle ? data_in  : data_p1;
  assign alignErr = isMisaligned(effSize, effAddr[1:0]);

  for (genvar g = 0; g < 4; g++) begin : gLane
    assign laneAddr[g] = effAddr + ADDR_WIDTH'(g);
  end

  always_comb begin
    case (effSize)
      2'b00:   nBytes = 1;
      2'b01:   nBytes = 2;
      default: nBytes = 4;
    endcase
  end

  always_comb begin
    rawRd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < nBytes) rawRd[8*laneOf(i, nBytes) +: 8] = mem[laneAddr[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (mov) begin
          if (alignErr || LATENCY == 1) begin
            nextState = DONE;
          end else begin
            nextState = WAIT;
            cntNext   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    enterDone = (nextState == DONE);
    mocNext   = enterDone;
    busyNext  = (nextState != IDLE);
    misNext   = accept & alignErr;
    commitWr  = enterDone & ~alignErr & ~effRw;
    commitRd  = enterDone & ~alignErr & effRw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      moc        <= 1'b0;
      busy       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      moc        <= mocNext;
      busy       <= busyNext;
      misaligned <= misNext;
      if (commitRd) data_out <= extend(rawRd, effSize, effSext);
    end
  end

  // A reset on the completion edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (commitWr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nBytes) mem[laneAddr[i]] <= effData[8*laneOf(i, nBytes) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_moc_ram.sv
// Bench for moc_ram: three instances (L2/BE, L3/LE, L4/BE) share one request bus;
// directed table, multi-cycle corner sequences, and randomized ops against a byte-array model.
module tb_moc_ram;

  logic        clk = 1'b0;
  logic        reset, mov, rw, sign_ext;
  logic [1:0]  size;
  logic [8:0]  addr;
  logic [31:0] data_in;
  logic [31:0] doutV [3];
  logic        mocV [3];
  logic        busyV [3];
  logic        misV [3];

  int nVec = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  moc_ram #(.ADDR_WIDTH(9), .LATENCY(2), .BIG_ENDIAN(1'b1)) dA (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .sign_ext(sign_ext),
    .addr(addr), .data_in(data_in), .data_out(doutV[0]), .moc(mocV[0]), .busy(busyV[0]),
    .misaligned(misV[0]));

  moc_ram #(.ADDR_WIDTH(9), .LATENCY(3), .BIG_ENDIAN(1'b0)) dB (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .sign_ext(sign_ext),
    .addr(addr), .data_in(data_in), .data_out(doutV[1]), .moc(mocV[1]), .busy(busyV[1]),
    .misaligned(misV[1]));

  moc_ram #(.ADDR_WIDTH(9), .LATENCY(4), .BIG_ENDIAN(1'b1)) dC (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .sign_ext(sign_ext),
    .addr(addr), .data_in(data_in), .data_out(doutV[2]), .moc(mocV[2]), .busy(busyV[2]),
    .misaligned(misV[2]));

  typedef struct {
    int          inst;
    bit          rw;
    bit [1:0]    size;
    bit          sx;
    logic [8:0]  addr;
    logic [31:0] data;
    bit          chkD;
    logic [31:0] expDout;
    bit          expMis;
    int          expLat;
  } vec_t;

  vec_t tbl[$];

  // Reference model for instance dA (LATENCY=2, big-endian)
  bit [7:0]  mm [512];
  bit [31:0] modelDout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic modelOp(input bit r, input bit [1:0] sz, input bit sx, input int a,
                         input bit [31:0] d, output bit [31:0] eD, output bit eM);
    int n;
    bit [31:0] v;
    n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    eM = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    if (!eM) begin
      if (r) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[a + i]);
        if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
        modelDout = v;
      end else begin
        for (int i = 0; i < n; i++) mm[a + i] = 8'((d >> (8*(n - 1 - i))) & 32'hFF);
      end
    end
    eD = modelDout;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((busyV[0] | busyV[1] | busyV[2]) && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 30) chk("idle timeout", 32'(k), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    mov   = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // Issue one request, return latency (cycles from accept edge to moc) and outputs in the moc cycle.
  task automatic req(input int inst, input bit r, input bit [1:0] sz, input bit sx,
                     input logic [8:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] dout, output logic mis);
    waitIdle();
    mov = 1'b1; rw = r; size = sz; sign_ext = sx; addr = a; data_in = d;
    @(posedge clk); #1;
    mov = 1'b0; addr = 9'($urandom); data_in = $urandom; size = 2'($urandom);
    sign_ext = 1'($urandom); rw = 1'($urandom);
    lat = 0;
    forever begin
      lat++;
      chk("busy in flight", 32'(busyV[inst]), 32'd1);
      if (mocV[inst]) break;
      if (lat >= 20) break;
      @(posedge clk); #1;
    end
    dout = doutV[inst];
    mis  = misV[inst];
    @(posedge clk); #1;
    chk("moc single pulse", 32'(mocV[inst]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] dout;
    logic mis;
    bit [31:0] eD;
    bit eM;

    reset = 1'b1; mov = 1'b0; rw = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; data_in = '0;
    @(posedge clk); #1;
    doReset();
    for (int i = 0; i < 3; i++) begin
      chk("reset moc", 32'(mocV[i]), 32'd0);
      chk("reset busy", 32'(busyV[i]), 32'd0);
      chk("reset misaligned", 32'(misV[i]), 32'd0);
      chk("reset data_out", doutV[i], 32'd0);
    end

    // inst rw size sx addr data chkD expDout expMis expLat
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 9'h010, 32'h11223344, 1'b1, 32'h00000000, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 9'h010, 32'h0,        1'b1, 32'h11223344, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b0, 9'h010, 32'h0,        1'b1, 32'h00000011, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b0, 9'h020, 32'h00000080, 1'b1, 32'h00000011, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b0, 9'h021, 32'h00000001, 1'b1, 32'h00000011, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b1, 9'h020, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b0, 9'h020, 32'h0,        1'b1, 32'h00000080, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b1, 9'h020, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 9'h030, 32'hAABBCCDD, 1'b1, 32'hFFFF8001, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b0, 9'h032, 32'h00001234, 1'b1, 32'hFFFF8001, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 9'h030, 32'h0,        1'b1, 32'hAABB1234, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 9'h031, 32'h0,        1'b1, 32'hAABB1234, 1'b1, 1});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b0, 9'h033, 32'h0000FFFF, 1'b1, 32'hAABB1234, 1'b1, 1});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 9'h030, 32'h0,        1'b1, 32'hAABB1234, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b0, 9'h033, 32'h0,        1'b1, 32'h00000034, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 2'd3, 1'b0, 9'h000, 32'h0,        1'b1, 32'h00000034, 1'b1, 1});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b0, 9'h030, 32'hAABBCCDD, 1'b0, 32'h0,        1'b0, 3});
    tbl.push_back('{1, 1'b0, 2'd1, 1'b0, 9'h032, 32'h00001234, 1'b0, 32'h0,        1'b0, 3});
    tbl.push_back('{1, 1'b1, 2'd2, 1'b0, 9'h030, 32'h0,        1'b1, 32'h1234CCDD, 1'b0, 3});
    tbl.push_back('{1, 1'b1, 2'd1, 1'b1, 9'h032, 32'h0,        1'b1, 32'h00001234, 1'b0, 3});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b0, 9'h054, 32'h12345678, 1'b0, 32'h0,        1'b0, 3});
    tbl.push_back('{2, 1'b0, 2'd2, 1'b0, 9'h040, 32'h01020304, 1'b0, 32'h0,        1'b0, 4});

    foreach (tbl[i]) begin
      req(tbl[i].inst, tbl[i].rw, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].data,
          lat, dout, mis);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].expLat));
      chk($sformatf("vec%0d misaligned", i), 32'(mis), 32'(tbl[i].expMis));
      if (tbl[i].chkD) chk($sformatf("vec%0d data_out", i), dout, tbl[i].expDout);
    end

    // mov held at cycles 1-2 during an L=3 op is ignored; a request at cycle 4 is accepted
    waitIdle();
    mov = 1'b1; rw = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 9'h050; data_in = 32'hCAFEF00D;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ignore moc c%0d", k), 32'(mocV[1]), 32'((k == 3) || (k == 7)));
      if (k == 7) chk("ignore read data", doutV[1], 32'hCAFEF00D);
      if (k == 1 || k == 2) begin
        mov = 1'b1; rw = 1'b0; size = 2'd2; addr = 9'h054; data_in = 32'h99999999;
      end else if (k == 4) begin
        mov = 1'b1; rw = 1'b1; size = 2'd2; addr = 9'h050;
      end else begin
        mov = 1'b0;
      end
    end
    req(1, 1'b1, 2'd2, 1'b0, 9'h054, 32'h0, lat, dout, mis);
    chk("ignored write absent", dout, 32'h12345678);

    // reset during WAIT of an L=4 write aborts it
    waitIdle();
    mov = 1'b1; rw = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 9'h040; data_in = 32'hDEADBEEF;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort moc c%0d", k), 32'(mocV[2]), 32'd0);
      if (k == 3) begin
        chk("abort busy", 32'(busyV[2]), 32'd0);
        chk("abort misaligned", 32'(misV[2]), 32'd0);
        chk("abort data_out", doutV[2], 32'd0);
      end
      mov   = 1'b0;
      reset = (k == 2);
    end
    req(2, 1'b1, 2'd2, 1'b0, 9'h040, 32'h0, lat, dout, mis);
    chk("abort prior contents", dout, 32'h01020304);
    chk("post-abort latency", 32'(lat), 32'd4);

    // randomized ops on dA against the byte-array model
    doReset();
    modelDout = '0;
    for (int i = 0; i < 32; i++) begin
      bit [31:0] d;
      d = $urandom;
      modelOp(1'b0, 2'd2, 1'b0, 256 + 4*i, d, eD, eM);
      req(0, 1'b0, 2'd2, 1'b0, 9'(256 + 4*i), d, lat, dout, mis);
      chk("preload data_out", dout, eD);
    end
    for (int i = 0; i < 150; i++) begin
      bit r, sx;
      bit [1:0] sz;
      int a;
      bit [31:0] d;
      r  = 1'($urandom);
      sz = 2'($urandom);
      sx = 1'($urandom);
      a  = 256 + int'($urandom_range(0, 127));
      d  = $urandom;
      modelOp(r, sz, sx, a, d, eD, eM);
      req(0, r, sz, sx, 9'(a), d, lat, dout, mis);
      chk($sformatf("rnd%0d latency", i), 32'(lat), eM ? 32'd1 : 32'd2);
      chk($sformatf("rnd%0d misaligned", i), 32'(mis), 32'(eM));
      chk($sformatf("rnd%0d data_out", i), dout, eD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
